// File: rtl/calc3_cmd_scheduler.sv
// calc3_cmd_scheduler: per-port command holding, round-robin issue to the alu/shift units,
// and routing of unit results or local errors back to the originating port's output lanes.
module calc3_cmd_scheduler #(
    parameter int DW = 32,
    parameter int NP = 4
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic [NP-1:0]    req_valid,
    output logic [NP-1:0]    req_ready,
    input  logic [NP*4-1:0]  req_cmd,
    input  logic [NP*DW-1:0] req_data1,
    input  logic [NP*DW-1:0] req_data2,
    input  logic [NP*2-1:0]  req_tag,
    output logic             alu_issue_valid,
    input  logic             alu_issue_ready,
    output logic [3:0]       alu_cmd,
    output logic [DW-1:0]    alu_op1,
    output logic [DW-1:0]    alu_op2,
    output logic [1:0]       alu_port,
    output logic [1:0]       alu_tag,
    input  logic             alu_rsp_valid,
    output logic             alu_rsp_ready,
    input  logic [1:0]       alu_rsp_code,
    input  logic [DW-1:0]    alu_rsp_data,
    input  logic [1:0]       alu_rsp_port,
    input  logic [1:0]       alu_rsp_tag,
    output logic             shf_issue_valid,
    input  logic             shf_issue_ready,
    output logic [3:0]       shf_cmd,
    output logic [DW-1:0]    shf_op1,
    output logic [DW-1:0]    shf_op2,
    output logic [1:0]       shf_port,
    output logic [1:0]       shf_tag,
    input  logic             shf_rsp_valid,
    output logic             shf_rsp_ready,
    input  logic [1:0]       shf_rsp_code,
    input  logic [DW-1:0]    shf_rsp_data,
    input  logic [1:0]       shf_rsp_port,
    input  logic [1:0]       shf_rsp_tag,
    output logic [NP*2-1:0]  out_resp,
    output logic [NP*DW-1:0] out_data,
    output logic [NP*2-1:0]  out_tag
);
    typedef enum logic [1:0] {EMPTY, HELD_ALU, HELD_SHF, HELD_ERR} st_t;

    st_t             st     [NP];
    st_t             st_nx  [NP];
    logic [3:0]      h_cmd  [NP];
    logic [DW-1:0]   h_op1  [NP];
    logic [DW-1:0]   h_op2  [NP];
    logic [1:0]      h_tag  [NP];
    logic [3:0]      obm    [NP];
    logic [3:0]      obm_nx [NP];
    logic [NP-1:0]   acc, cmd_ok, alu_req, shf_req, alu_hit, shf_hit, err_dlv;
    logic [1:0]      alu_ptr, shf_ptr, alu_lock_p, shf_lock_p, alu_gnt, shf_gnt;
    logic            alu_lock_v, shf_lock_v, alu_fire, shf_fire;
    logic [2:0]      alu_pick, shf_pick;
    logic [NP*2-1:0] resp_nx, tag_nx;
    logic [NP*DW-1:0] data_nx;

    // {found, port}: first requester at or after ptr, wrapping
    function automatic logic [2:0] rr_pick(input logic [NP-1:0] req, input logic [1:0] ptr);
        logic [2:0] r;
        logic [1:0] k;
        r = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) r = {1'b1, k};
        end
        return r;
    endfunction

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            req_ready[p] = st[p] == EMPTY && obm[p] != 4'hF;
            alu_req[p]   = st[p] == HELD_ALU;
            shf_req[p]   = st[p] == HELD_SHF;
        end
    end

    assign alu_rsp_ready = 1'b1;
    assign shf_rsp_ready = !(alu_rsp_valid && alu_rsp_port == shf_rsp_port);

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            acc[p]     = req_valid[p] & req_ready[p];
            cmd_ok[p]  = (req_cmd[p*4 +: 4] inside {4'd1, 4'd2, 4'd5, 4'd6}) && !obm[p][req_tag[p*2 +: 2]];
            alu_hit[p] = alu_rsp_valid && alu_rsp_port == 2'(p);
            shf_hit[p] = shf_rsp_valid && shf_rsp_ready && shf_rsp_port == 2'(p);
            err_dlv[p] = st[p] == HELD_ERR && !alu_hit[p] && !shf_hit[p];
        end
    end

    // An offered but unaccepted grant is locked so the issue fields stay stable
    always_comb begin
        alu_pick        = rr_pick(alu_req, alu_ptr);
        alu_gnt         = alu_lock_v ? alu_lock_p : alu_pick[1:0];
        alu_issue_valid = alu_lock_v | alu_pick[2];
        alu_cmd         = h_cmd[alu_gnt];
        alu_op1         = h_op1[alu_gnt];
        alu_op2         = h_op2[alu_gnt];
        alu_port        = alu_gnt;
        alu_tag         = h_tag[alu_gnt];
        alu_fire        = alu_issue_valid & alu_issue_ready;
        shf_pick        = rr_pick(shf_req, shf_ptr);
        shf_gnt         = shf_lock_v ? shf_lock_p : shf_pick[1:0];
        shf_issue_valid = shf_lock_v | shf_pick[2];
        shf_cmd         = h_cmd[shf_gnt];
        shf_op1         = h_op1[shf_gnt];
        shf_op2         = h_op2[shf_gnt];
        shf_port        = shf_gnt;
        shf_tag         = h_tag[shf_gnt];
        shf_fire        = shf_issue_valid & shf_issue_ready;
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            st_nx[p] = st[p];
            case (st[p])
                EMPTY:    if (acc[p]) st_nx[p] = !cmd_ok[p] ? HELD_ERR : req_cmd[p*4+2] ? HELD_SHF : HELD_ALU;
                HELD_ALU: if (alu_fire && alu_gnt == 2'(p)) st_nx[p] = EMPTY;
                HELD_SHF: if (shf_fire && shf_gnt == 2'(p)) st_nx[p] = EMPTY;
                HELD_ERR: if (err_dlv[p]) st_nx[p] = EMPTY;
                default:  st_nx[p] = EMPTY;
            endcase
        end
    end

    // Results for tags not outstanding (stale after reset) are dropped; a set on accept wins over a clear
    always_comb begin
        resp_nx = '0;
        data_nx = '0;
        tag_nx  = '0;
        for (int p = 0; p < NP; p++) begin
            obm_nx[p] = obm[p];
            if (alu_hit[p]) begin
                if (obm[p][alu_rsp_tag]) begin
                    resp_nx[p*2 +: 2]  = alu_rsp_code;
                    data_nx[p*DW +: DW] = alu_rsp_data;
                    tag_nx[p*2 +: 2]   = alu_rsp_tag;
                end
                obm_nx[p][alu_rsp_tag] = 1'b0;
            end else if (shf_hit[p]) begin
                if (obm[p][shf_rsp_tag]) begin
                    resp_nx[p*2 +: 2]  = shf_rsp_code;
                    data_nx[p*DW +: DW] = shf_rsp_data;
                    tag_nx[p*2 +: 2]   = shf_rsp_tag;
                end
                obm_nx[p][shf_rsp_tag] = 1'b0;
            end else if (err_dlv[p]) begin
                resp_nx[p*2 +: 2] = 2'd2;
                tag_nx[p*2 +: 2]  = h_tag[p];
            end
            if (acc[p] && cmd_ok[p]) obm_nx[p][req_tag[p*2 +: 2]] = 1'b1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                st[p]  <= EMPTY;
                obm[p] <= '0;
            end
            alu_ptr    <= '0;
            shf_ptr    <= '0;
            alu_lock_v <= 1'b0;
            shf_lock_v <= 1'b0;
            alu_lock_p <= '0;
            shf_lock_p <= '0;
            out_resp   <= '0;
            out_data   <= '0;
            out_tag    <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                st[p]  <= st_nx[p];
                obm[p] <= obm_nx[p];
            end
            alu_ptr    <= alu_fire ? alu_gnt + 2'd1 : alu_ptr;
            shf_ptr    <= shf_fire ? shf_gnt + 2'd1 : shf_ptr;
            alu_lock_v <= alu_issue_valid & !alu_issue_ready;
            shf_lock_v <= shf_issue_valid & !shf_issue_ready;
            alu_lock_p <= alu_gnt;
            shf_lock_p <= shf_gnt;
            out_resp   <= resp_nx;
            out_data   <= data_nx;
            out_tag    <= tag_nx;
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                h_cmd[p] <= req_cmd[p*4 +: 4];
                h_op1[p] <= req_data1[p*DW +: DW];
                h_op2[p] <= req_data2[p*DW +: DW];
                h_tag[p] <= req_tag[p*2 +: 2];
            end
        end
    end
endmodule
